wb_rr_arbiter: RTL and testbench
================================

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of wishbone masters sharing one bus (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max granted cycles without slave ack before forced release (legal 1..65535).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rstn_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cyc_i  input  NUM_MASTERS  per-master wb_cyc request, bit i = master i.
REQ-006 SHALL have port ack_i  input  1  shared slave wb_ack, observed only.
REQ-007 SHALL have port gnt_o  output  NUM_MASTERS  one-hot-or-zero bus grant, bit i drives master i wb_gnt.
REQ-008 SHALL have port owner_o  output  max(1,$clog2(NUM_MASTERS))  index of current or last owner.
REQ-009 SHALL have port busy_o  output  1  high while any grant held.
REQ-010 SHALL have port timeout_o  output  1  one-cycle pulse on forced release.

Function
REQ-011 SHALL implement states IDLE, GRANT, BLOCK in a registered state machine.
REQ-012 SHALL drive gnt_o, busy_o, owner_o, timeout_o from registers only; no combinational path input->output.
REQ-013 IDLE: if any cyc_i bit set, SHALL select winner by round-robin starting at (owner_o+1) mod NUM_MASTERS, ascending with wrap, and go to GRANT.
REQ-014 Grant latency SHALL be exactly 1 cycle: cyc_i seen high in IDLE at edge N -> gnt_o bit high after edge N.
REQ-015 GRANT: gnt_o SHALL equal one-hot(owner_o), busy_o=1, while cyc_i[owner_o]=1.
REQ-016 GRANT: cyc_i[owner_o]=0 at an edge SHALL clear gnt_o and return to IDLE; at least one cycle with gnt_o=0 between successive owners.
REQ-017 Requests from non-owners during GRANT SHALL be ignored (no preemption) and remain pending.
REQ-018 SHALL keep a cycle counter, width $clog2(TIMEOUT_CYCLES+1), cleared on entry to GRANT and on every cycle with ack_i=1.
REQ-019 Counter SHALL increment each GRANT cycle with ack_i=0 and saturate, never wrap.
REQ-020 Counter reaching TIMEOUT_CYCLES in GRANT with ack_i=0 SHALL clear gnt_o, pulse timeout_o for exactly one cycle, go to BLOCK.
REQ-021 ack_i=1 on the same edge counter would reach TIMEOUT_CYCLES SHALL win: clear counter, stay GRANT.
REQ-022 cyc_i[owner] drop and timeout on the same edge SHALL take normal release (IDLE, no timeout_o).
REQ-023 BLOCK: gnt_o=0, busy_o=0; SHALL stay until cyc_i[owner_o]=0, then go to IDLE.
REQ-024 owner_o SHALL update only when a new grant issues and hold its value in IDLE and BLOCK.
REQ-025 With a single requester, it SHALL be re-granted after the mandatory one idle cycle.
REQ-026 ack_i outside GRANT SHALL be ignored.

Reset
REQ-027 rstn_i low SHALL asynchronously force state IDLE, gnt_o=0, busy_o=0, timeout_o=0, counter=0, owner_o=NUM_MASTERS-1 (so master 0 has first priority).
REQ-028 Reset asserted mid-GRANT SHALL drop the grant immediately without waiting for a clock edge.
REQ-029 First grant decision SHALL occur on the first rising edge after rstn_i deasserts.

Verification
REQ-030 Reset release, cyc_i=2'b11 -> gnt_o=2'b01 one cycle later, owner_o=0, busy_o=1.
REQ-031 Master 0 drops cyc with cyc_i[1] still high -> one cycle gnt_o=2'b00, then gnt_o=2'b10, owner_o=1.
REQ-032 NUM_MASTERS=4, owner 1, cyc_i=4'b1001 on release -> next grant to master 3, then master 0.
REQ-033 TIMEOUT_CYCLES=4, master 0 granted, ack_i=0 -> gnt_o cleared after 4 GRANT cycles, timeout_o high one cycle, no new grant until cyc_i[0]=0.
REQ-034 TIMEOUT_CYCLES=4, ack_i pulsed every 3rd cycle for 20 cycles -> timeout_o stays 0, gnt_o held throughout.
REQ-035 rstn_i pulsed low mid-GRANT between clock edges -> gnt_o=0 immediately, owner_o=NUM_MASTERS-1.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone arbitration bundle: per-master cyc requests and shared ack in, grant/status out.
// The arbiter sits on the slave modport; the master modport is the requesting side.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] cyc_i;
  logic                   ack_i;
  logic [NUM_MASTERS-1:0] gnt_o;
  logic [OW-1:0]          owner_o;
  logic                   busy_o;
  logic                   timeout_o;

  modport slave (
    input  cyc_i,
    input  ack_i,
    output gnt_o,
    output owner_o,
    output busy_o,
    output timeout_o
  );

  modport master (
    output cyc_i,
    output ack_i,
    input  gnt_o,
    input  owner_o,
    input  busy_o,
    input  timeout_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin wishbone bus arbiter with ack-watchdog forced release; grant 1 cycle after request.
// No preemption: an owner holds the bus until it drops cyc or stalls TIMEOUT_CYCLES without ack.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  wb_rr_arbiter_if.slave        bus
);

  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [OW-1:0] OWNER_RST = OW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BLOCK = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [NUM_MASTERS-1:0]   req_rot;
  logic                     win_vld;
  int                       win_ofs;
  int                       win_sum;
  logic [OW-1:0]            win_idx;
  logic                     cyc_own;

  // Rotate requests so bit 0 is the master just after the last owner; lowest set bit wins.
  always_comb begin
    req_dbl = {bus.cyc_i, bus.cyc_i};
    req_rot = NUM_MASTERS'(req_dbl >> (32'(owner_q) + 32'd1));
    win_vld = |req_rot;
    win_ofs = 0;
    for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        win_ofs = j;
      end
    end
    win_sum = 32'(owner_q) + 1 + win_ofs;
    if (win_sum >= NUM_MASTERS) begin
      win_sum = win_sum - NUM_MASTERS;
    end
    win_idx = OW'(win_sum);
    cyc_own = |(bus.cyc_i & (NUM_MASTERS'(1) << owner_q));
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (win_vld) begin
          state_d = S_GRANT;
          owner_d = win_idx;
          gnt_d   = NUM_MASTERS'(1) << win_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      S_GRANT: begin
        // Normal release beats the watchdog, and an ack beats the watchdog.
        if (!cyc_own) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (bus.ack_i) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d   = S_BLOCK;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          cnt_d     = CNT_MAX;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
        end
      end

      S_BLOCK: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (!cyc_own) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      owner_q   <= OWNER_RST;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.owner_o   = owner_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = timeout_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rstn_i) $onehot0(gnt_q));
  a_busy_match:  assert property (@(posedge clk) disable iff (!rstn_i) busy_q == (|gnt_q));

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed-vector bench for wb_rr_arbiter (4 masters, watchdog of 4 cycles) with a queued scoreboard.
module tb_wb_rr_arbiter;

  localparam int N = 4;
  localparam int T = 4;

  logic clk     = 1'b0;
  logic rstn_i  = 1'b0;
  logic mid_chk = 1'b0;

  wb_rr_arbiter_if #(.NUM_MASTERS(N)) bus ();

  wb_rr_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (T)
  ) u_dut (
    .clk    (clk),
    .rstn_i (rstn_i),
    .bus    (bus.slave)
  );

  typedef struct {
    int         id;
    logic [3:0] gnt;
    logic [1:0] own;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   vec_id = 0;

  initial forever #5 clk = ~clk;

  task automatic push(input logic [3:0] g, input logic [1:0] o, input logic b, input logic t);
    exp_t e;
    e.id   = vec_id;
    e.gnt  = g;
    e.own  = o;
    e.busy = b;
    e.to   = t;
    sb_q.push_back(e);
  endtask

  // Apply inputs on the falling edge; expectation is the state after the next rising edge.
  task automatic vec(input logic r, input logic [3:0] c, input logic a,
                     input logic [3:0] g, input logic [1:0] o, input logic b, input logic t);
    @(negedge clk);
    rstn_i     = r;
    bus.cyc_i  = c;
    bus.ack_i  = a;
    vec_id++;
    push(g, o, b, t);
  endtask

  // Reset dropped between edges must clear outputs before any rising edge.
  task automatic mid_reset(input logic [3:0] c);
    @(negedge clk);
    rstn_i    = 1'b0;
    bus.cyc_i = c;
    bus.ack_i = 1'b0;
    vec_id++;
    push(4'b0000, 2'd3, 1'b0, 1'b0);
    #1 mid_chk = 1'b1;
    #1 mid_chk = 1'b0;
    vec_id++;
    push(4'b0000, 2'd3, 1'b0, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge mid_chk);
      #1;
      if (sb_q.size() != 0) begin
        cur = sb_q.pop_front();
        n_cmp++;
        if ({bus.gnt_o, bus.owner_o, bus.busy_o, bus.timeout_o} !==
            {cur.gnt, cur.own, cur.busy, cur.to}) begin
          n_bad++;
          $display("FAIL vec%0d: got gnt=%b owner=%0d busy=%b timeout=%b, want gnt=%b owner=%0d busy=%b timeout=%b",
                   cur.id, bus.gnt_o, bus.owner_o, bus.busy_o, bus.timeout_o,
                   cur.gnt, cur.own, cur.busy, cur.to);
        end
      end
    end
  end

  initial begin
    bus.cyc_i = '0;
    bus.ack_i = 1'b0;

    // reset state, then first grant on first edge after release
    vec(0, 4'b0000, 0, 4'b0000, 2'd3, 0, 0);
    vec(0, 4'b0011, 0, 4'b0000, 2'd3, 0, 0);
    vec(1, 4'b0011, 0, 4'b0001, 2'd0, 1, 0);
    vec(1, 4'b0011, 1, 4'b0001, 2'd0, 1, 0);
    // owner 0 releases with master 1 pending: one idle cycle then master 1
    vec(1, 4'b0010, 0, 4'b0000, 2'd0, 0, 0);
    vec(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    // non-owner requests ignored while granted
    vec(1, 4'b1011, 1, 4'b0010, 2'd1, 1, 0);
    // release with 1001 pending from owner 1: master 3 next, then master 0
    vec(1, 4'b1001, 0, 4'b0000, 2'd1, 0, 0);
    vec(1, 4'b1001, 0, 4'b1000, 2'd3, 1, 0);
    vec(1, 4'b1001, 1, 4'b1000, 2'd3, 1, 0);
    vec(1, 4'b0001, 0, 4'b0000, 2'd3, 0, 0);
    vec(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    // watchdog: 4 granted cycles without ack forces release
    vec(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    vec(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    vec(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    vec(1, 4'b0001, 0, 4'b0000, 2'd0, 0, 1);
    // blocked until master 0 drops cyc; ack ignored meanwhile
    vec(1, 4'b0011, 0, 4'b0000, 2'd0, 0, 0);
    vec(1, 4'b0011, 1, 4'b0000, 2'd0, 0, 0);
    vec(1, 4'b0010, 0, 4'b0000, 2'd0, 0, 0);
    vec(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    // ack on the boundary cycle wins over the watchdog
    vec(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    vec(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    vec(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    vec(1, 4'b0010, 1, 4'b0010, 2'd1, 1, 0);
    vec(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    vec(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    vec(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    // cyc drop on the watchdog edge is a normal release
    vec(1, 4'b0000, 0, 4'b0000, 2'd1, 0, 0);
    // single requester re-granted after one idle cycle
    vec(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    vec(1, 4'b0000, 0, 4'b0000, 2'd1, 0, 0);
    vec(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    // periodic ack keeps the grant alive indefinitely
    for (int i = 0; i < 20; i++) begin
      vec(1, 4'b0010, (i % 3 == 2), 4'b0010, 2'd1, 1, 0);
    end
    mid_reset(4'b0010);
    vec(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    vec(1, 4'b0000, 0, 4'b0000, 2'd1, 0, 0);
    vec(1, 4'b0101, 0, 4'b0100, 2'd2, 1, 0);
    vec(1, 4'b0001, 0, 4'b0000, 2'd2, 0, 0);
    vec(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    vec(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
